// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Round-robin arbiter and sequencer sharing one APB master bridge
//            between NREQ requesters. It latches the winning request, drives
//            the bridge inputs, and returns read data and status. A transfer
//            ends on completion, on slave error or on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    // requester side
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    // bridge side
    output logic                 transfer,
    output logic                 READ_WRITE,
    output logic [AW-1:0]        apb_write_paddr,
    output logic [AW-1:0]        apb_read_paddr,
    output logic [DW-1:0]        apb_write_data,
    // APB bus observation
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    input  logic [DW-1:0]        PRDATA
);

    // Index width for the requester pointer and the timeout counter width.
    localparam int c_IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen at the edge where the abort must be taken.
    localparam int c_TLIM = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [c_CW-1:0] c_TLIM_V = c_CW'(c_TLIM);
    localparam logic [NREQ-1:0] c_ONE    = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_IW-1:0]     r_ptr;
    logic [c_IW-1:0]     r_idx;
    logic [c_CW-1:0]     r_cnt;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [DW-1:0]       r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic                r_transfer;
    logic                r_read;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;

    logic                w_any;
    logic [c_IW-1:0]     w_pick_idx;
    logic [NREQ-1:0]     w_pick_oh;
    logic                w_cmpl;
    logic                w_tmo_hit;

    // (base + off) mod NREQ for off in 0..NREQ, without a divider.
    function automatic logic [c_IW-1:0] f_wrap(input logic [c_IW-1:0] base,
                                               input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return c_IW'(s);
    endfunction

    // Round-robin search: first pending requester at or after the pointer.
    always_comb begin
        w_any      = 1'b0;
        w_pick_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && req_valid[f_wrap(r_ptr, k)]) begin
                w_any      = 1'b1;
                w_pick_idx = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_pick_oh = c_ONE << w_pick_idx;
    assign w_cmpl    = PSEL & PENABLE & PREADY;

    // A zero TIMEOUT removes the abort path entirely.
    generate
        if (TIMEOUT > 0) begin : g_tmo_en
            assign w_tmo_hit = (r_cnt == c_TLIM_V);
        end else begin : g_tmo_dis
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    // Sequencer: grant/latch in IDLE, watch the bus in BUSY, respond in DONE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_transfer  <= 1'b0;
            r_read      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_pick_oh;
                        r_idx      <= w_pick_idx;
                        r_read     <= ~req_write[w_pick_idx];
                        r_addr     <= req_addr[int'(w_pick_idx)*AW +: AW];
                        r_wdata    <= req_wdata[int'(w_pick_idx)*DW +: DW];
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_transfer <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Slave error wins over a completion in the same cycle;
                    // a genuine completion wins over a coincident timeout.
                    if (PSLVERR) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_transfer  <= 1'b0;
                        r_rsp_valid <= r_gnt;
                        r_state     <= S_DONE;
                    end else if (w_cmpl) begin
                        r_rsp_err   <= 1'b0;
                        // Writes return zero so no stale bus data leaks out.
                        r_rsp_rdata <= r_read ? PRDATA : '0;
                        r_transfer  <= 1'b0;
                        r_rsp_valid <= r_gnt;
                        r_state     <= S_DONE;
                    end else if (w_tmo_hit) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_transfer  <= 1'b0;
                        r_rsp_valid <= r_gnt;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= '0;
                    r_gnt       <= '0;
                    r_cnt       <= '0;
                    r_busy      <= 1'b0;
                    r_ptr       <= f_wrap(r_idx, 1);
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt             = r_gnt;
    assign busy            = r_busy;
    assign transfer        = r_transfer;
    assign READ_WRITE      = r_read;
    assign apb_write_paddr = r_addr;
    assign apb_read_paddr  = r_addr;
    assign apb_write_data  = r_wdata;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;

endmodule
`default_nettype wire
